// File: rtl/result_store_unit.sv
// Result store unit: turns controller J/K/L/M stores into row-major {addr,data} writes
// through a show-ahead FIFO. Optional macro RESULT_STORE_PARITY_EN adds mem_parity.
module result_store_unit #(
  parameter int WIDTH  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              data_we,
  input  logic [1:0]        jklm_select,
  input  logic              next_row,
  input  logic              column,
  input  logic [WIDTH-1:0]  dataJ,
  input  logic [WIDTH-1:0]  dataK,
  input  logic [WIDTH-1:0]  dataL,
  input  logic [WIDTH-1:0]  dataM,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_data,
  output logic              done,
  output logic              overflow
`ifdef RESULT_STORE_PARITY_EN
  ,
  output logic              mem_parity
`endif
);

  localparam int PW    = $clog2(ROWS + COLS + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PW-1:0]     blk_row_q, blk_row_d;
  logic [PW-1:0]     blk_col_q, blk_col_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];
  logic [WIDTH-1:0]  data_mem_q [DEPTH];
  logic [WIDTH-1:0]  data_mem_d [DEPTH];
`ifdef RESULT_STORE_PARITY_EN
  logic              par_mem_q  [DEPTH];
  logic              par_mem_d  [DEPTH];
`endif
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic              pop, push, full;
  logic [WIDTH-1:0]  sel_data;
  logic [31:0]       addr_full;
  logic [31:0]       col_next;

  always_comb begin
    pop  = (count_q != '0) && mem_ready;
    full = (count_q == (PTR_W+1)'(DEPTH));
    // A full FIFO still accepts when the head leaves on the same edge.
    push = data_we && !done_q && (!full || pop);

    unique case (jklm_select)
      2'b00:   sel_data = dataJ;
      2'b01:   sel_data = dataK;
      2'b10:   sel_data = dataL;
      default: sel_data = dataM;
    endcase

    addr_full = (32'(blk_row_q) + 32'(jklm_select[1])) * 32'(COLS)
              + 32'(blk_col_q) + 32'(jklm_select[0]);

    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
`ifdef RESULT_STORE_PARITY_EN
    par_mem_d  = par_mem_q;
`endif
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      addr_mem_d[wr_ptr_q] = addr_full[ADDR_W-1:0];
      data_mem_d[wr_ptr_q] = sel_data;
`ifdef RESULT_STORE_PARITY_EN
      par_mem_d[wr_ptr_q]  = ^sel_data;
`endif
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    blk_row_d = blk_row_q;
    blk_col_d = blk_col_q;
    col_next  = 32'(blk_col_q) + 32'd2;
    // Pointers freeze once done; no further store can be accepted anyway.
    if (!done_q) begin
      if (next_row) begin
        blk_row_d = PW'(32'(blk_row_q) + 32'd2);
        blk_col_d = '0;
      end else if (push && column) begin
        if (col_next >= 32'(COLS)) begin
          blk_col_d = '0;
          blk_row_d = PW'(32'(blk_row_q) + 32'd2);
        end else begin
          blk_col_d = PW'(col_next);
        end
      end
    end

    done_d     = done_q || (32'(blk_row_d) >= 32'(ROWS));
    overflow_d = overflow_q || (data_we && !push);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      blk_row_q  <= '0;
      blk_col_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      addr_mem_q <= '{default: '0};
      data_mem_q <= '{default: '0};
`ifdef RESULT_STORE_PARITY_EN
      par_mem_q  <= '{default: 1'b0};
`endif
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      blk_row_q  <= blk_row_d;
      blk_col_q  <= blk_col_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
`ifdef RESULT_STORE_PARITY_EN
      par_mem_q  <= par_mem_d;
`endif
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign mem_valid = (count_q != '0);
  assign mem_addr  = addr_mem_q[rd_ptr_q];
  assign mem_data  = data_mem_q[rd_ptr_q];
`ifdef RESULT_STORE_PARITY_EN
  assign mem_parity = par_mem_q[rd_ptr_q];
`endif
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/result_store_unit.md
Name: result_store_unit

Overview:
- Sits directly downstream of the sequencing controller.
- Consumes the controller's store strobe (data_we), J/K/L/M result select, next_row and column strobes, plus the four 2x2-block result registers J, K, L, M.
- Computes the row-major result-memory address for each store and queues {addr, data} in a small FIFO.
- Drains the FIFO to the result memory over a valid/ready handshake, so memory stalls never stall the controller.

Parameters:
- WIDTH, 32, result word width
- ROWS, 4, result matrix rows (even, >= 2)
- COLS, 4, result matrix columns (even, >= 2)
- ADDR_W, 4, memory address width (2^ADDR_W >= ROWS*COLS)
- DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
- Clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- data_we  in  1  store strobe from controller
- jklm_select  in  2  selects result: 00=J, 01=K, 10=L, 11=M
- next_row  in  1  advance block row
- column  in  1  with data_we: this store completes the current block column
- dataJ, dataK, dataL, dataM  in  WIDTH each  result registers
- mem_valid  out  1  FIFO head valid
- mem_ready  in  1  memory accepts head this cycle
- mem_addr  out  ADDR_W  head address
- mem_data  out  WIDTH  head data
- done  out  1  sticky: all block rows consumed
- overflow  out  1  sticky: store dropped (FIFO full or after done)

Behaviour:
- Reset (async): blk_row=0, blk_col=0, FIFO empty, mem_valid=0, mem_addr=0, mem_data=0, done=0, overflow=0.
- Address:
  - addr = (blk_row + jklm_select[1])*COLS + blk_col + jklm_select[0].
  - Truncated to ADDR_W.
  - Data is the selected register sampled on the same edge.
- Push occurs when data_we=1, done=0, and the FIFO is not full, or is full with a pop on the same edge.
- Drop cases (entry discarded, overflow set to 1):
  - data_we=1 with done=1.
  - data_we=1 with the FIFO full and no pop.
- Pop: mem_valid && mem_ready. Head advances on that edge.
- FIFO is show-ahead. mem_addr/mem_data/mem_valid come from registered head state.
- Latency: a store into an empty FIFO at edge n gives mem_valid=1 after edge n (one cycle).
- Simultaneous push and pop:
  - Occupancy unchanged.
  - On an empty FIFO, push only (mem_valid was 0, so no pop).
- Block pointer update, evaluated per edge in priority order:
  1. next_row=1: blk_row += 2, blk_col = 0. Applies after any same-cycle store, which uses the old pointers.
  2. Else if an accepted store has column=1:
     - blk_col += 2.
     - If the new blk_col >= COLS: blk_col = 0 and blk_row += 2.
- When blk_row becomes >= ROWS, done goes to 1 on the same edge and stays set until reset.
- FIFO continues draining after done.
- Stores on the edge that sets done are accepted, because they used the pre-update pointers.
- Dropped stores do not move the pointers.
- done and overflow clear only on reset.
- Reset mid-operation: FIFO contents discarded, all outputs return to reset values immediately.
- mem_data/mem_addr hold their value while mem_valid=1 and mem_ready=0.

Optional Feature:
- Macro: RESULT_STORE_PARITY_EN.
- Defined:
  - Adds output mem_parity (1 bit) = even parity (XOR reduction) of mem_data.
  - Parity is stored in the FIFO alongside data and is 0 on reset.
- Undefined: port and storage absent; all other behaviour identical.

Test Plan:
- Reset, then idle -> mem_valid=0, done=0, overflow=0, mem_addr=0.
- Pointers (0,0), dataL=0xDEADBEEF, data_we=1, jklm_select=10, mem_ready=1 -> next cycle mem_valid=1, mem_addr=4, mem_data=0xDEADBEEF; popped the following edge.
- Four stores J,K,L,M with column=1 on M, then one store with jklm_select=00 -> addresses 0,1,4,5, then 2.
- mem_ready=0, issue 5 stores -> first 4 queued, overflow=1 after the 5th. Raise mem_ready -> addresses emerge in order, mem_valid falls after 4 pops.
- Two next_row pulses (ROWS=4) -> done=1. A later data_we=1 is not queued and sets overflow=1.
- Reset asserted while the FIFO holds 3 entries -> mem_valid=0 without a clock edge. After release, the store at jklm_select=11 gives mem_addr=5.
